// File: rtl/fwd_pkg.sv
// Shared definitions for the EX-stage forwarding / load-use hazard unit:
// forwarding select encodings, default register-address width and the
// control part of a shadow-pipeline stage entry.
package fwd_pkg;

    localparam int FWD_REG_AW = 5;

    localparam logic [1:0] FWD_SEL_RF  = 2'b00;
    localparam logic [1:0] FWD_SEL_WB  = 2'b01;
    localparam logic [1:0] FWD_SEL_MEM = 2'b10;

    // Control bits of one in-flight instruction. The register addresses
    // are kept beside it because their width is a module parameter.
    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_read;
    } stage_ctl_t;

endpackage

// File: rtl/fwd_src_match.sv
// Compares one source register address against two older writers and
// returns the forwarding select. The "mem" writer is the younger one and
// wins over the "wb" writer. Address 0 never matches.
module fwd_src_match
    import fwd_pkg::*;
#(
    parameter int REG_AW = FWD_REG_AW
) (
    input  logic [REG_AW-1:0] rs,
    input  logic              mem_wr,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_wr,
    input  logic [REG_AW-1:0] wb_rd,
    output logic [1:0]        sel
);

    // Youngest matching writer decides the select.
    always_comb begin
        sel = FWD_SEL_RF;
        if (wb_wr && (wb_rd != '0) && (wb_rd == rs)) begin
            sel = FWD_SEL_WB;
        end
        if (mem_wr && (mem_rd != '0) && (mem_rd == rs)) begin
            sel = FWD_SEL_MEM;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding select and load-use stall generator with its own
// shadow pipeline of EX/MEM/WB destination registers.
// Optional feature macro: FWD_HAZARD_PERF_CNT_EN adds saturating
// stall_cnt_o / fwd_cnt_o performance counters.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_AW  = FWD_REG_AW,
    parameter int NUM_SRC = 2
`ifdef FWD_HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W   = 32
`endif
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      hold_i,
    input  logic                      flush_i,
    input  logic                      id_valid_i,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0]         id_rd_i,
    input  logic                      id_reg_write_i,
    input  logic                      id_mem_read_i,
    output logic                      stall_o,
    output logic [2*NUM_SRC-1:0]      ex_fwd_sel_o
`ifdef FWD_HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]          stall_cnt_o,
    output logic [CNT_W-1:0]          fwd_cnt_o
`endif
);

    stage_ctl_t                ex_ctl, mem_ctl, wb_ctl;
    logic [REG_AW-1:0]         ex_rd, mem_rd, wb_rd;
    logic [NUM_SRC*REG_AW-1:0] ex_rs;

    logic                 mem_wr, wb_wr, ex_load_wr;
    logic [2*NUM_SRC-1:0] fwd_raw;
    logic [NUM_SRC-1:0]   ld_hit;

    // mem_read travels down with the entry but only the EX copy is consumed.
    logic unused_ctl;
    assign unused_ctl = mem_ctl.mem_read ^ wb_ctl.mem_read;

    assign mem_wr     = mem_ctl.valid & mem_ctl.reg_write;
    assign wb_wr      = wb_ctl.valid & wb_ctl.reg_write;
    assign ex_load_wr = ex_ctl.valid & ex_ctl.reg_write & ex_ctl.mem_read;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        logic [1:0] ld_sel;

        fwd_src_match #(.REG_AW(REG_AW)) u_fwd (
            .rs     (ex_rs[k*REG_AW +: REG_AW]),
            .mem_wr (mem_wr),
            .mem_rd (mem_rd),
            .wb_wr  (wb_wr),
            .wb_rd  (wb_rd),
            .sel    (fwd_raw[2*k +: 2])
        );

        // Same matcher, pointed at the load sitting in EX vs. the ID sources.
        fwd_src_match #(.REG_AW(REG_AW)) u_ld (
            .rs     (id_rs_i[k*REG_AW +: REG_AW]),
            .mem_wr (ex_load_wr),
            .mem_rd (ex_rd),
            .wb_wr  (1'b0),
            .wb_rd  ({REG_AW{1'b0}}),
            .sel    (ld_sel)
        );

        assign ld_hit[k] = (ld_sel == FWD_SEL_MEM);
    end

    assign ex_fwd_sel_o = ex_ctl.valid ? fwd_raw : '0;
    assign stall_o      = id_valid_i & ~flush_i & (|ld_hit);

    // Shadow pipeline: reset clears, hold freezes, otherwise shift by one
    // and drop a bubble into EX on flush or load-use stall.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_ctl  <= '0;
            mem_ctl <= '0;
            wb_ctl  <= '0;
            ex_rd   <= '0;
            mem_rd  <= '0;
            wb_rd   <= '0;
            ex_rs   <= '0;
        end else if (!hold_i) begin
            wb_ctl  <= mem_ctl;
            wb_rd   <= mem_rd;
            mem_ctl <= ex_ctl;
            mem_rd  <= ex_rd;
            ex_rd   <= id_rd_i;
            ex_rs   <= id_rs_i;
            if (flush_i || stall_o) begin
                ex_ctl <= '0;
            end else begin
                ex_ctl.valid     <= id_valid_i;
                ex_ctl.reg_write <= id_reg_write_i;
                ex_ctl.mem_read  <= id_mem_read_i;
            end
        end
    end

`ifdef FWD_HAZARD_PERF_CNT_EN
    // Saturating event counters, advancing only on un-held clocks.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            fwd_cnt_o   <= '0;
        end else if (!hold_i) begin
            if (stall_o && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
            if ((|ex_fwd_sel_o) && (fwd_cnt_o != '1)) begin
                fwd_cnt_o <= fwd_cnt_o + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: instruction-level pipeline model plus
// directed sequences with hand-computed expectations.
module tb_fwd_hazard_unit;

    localparam int REG_AW  = 5;
    localparam int NUM_SRC = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      rst_i = 1'b1;
    logic                      hold_i = 1'b0;
    logic                      flush_i = 1'b0;
    logic                      id_valid_i = 1'b0;
    logic [NUM_SRC*REG_AW-1:0] id_rs_i = '0;
    logic [REG_AW-1:0]         id_rd_i = '0;
    logic                      id_reg_write_i = 1'b0;
    logic                      id_mem_read_i = 1'b0;
    logic                      stall_o;
    logic [2*NUM_SRC-1:0]      ex_fwd_sel_o;
`ifdef FWD_HAZARD_PERF_CNT_EN
    logic [31:0]               stall_cnt_o;
    logic [31:0]               fwd_cnt_o;
`endif

    fwd_hazard_unit #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .hold_i         (hold_i),
        .flush_i        (flush_i),
        .id_valid_i     (id_valid_i),
        .id_rs_i        (id_rs_i),
        .id_rd_i        (id_rd_i),
        .id_reg_write_i (id_reg_write_i),
        .id_mem_read_i  (id_mem_read_i),
        .stall_o        (stall_o),
        .ex_fwd_sel_o   (ex_fwd_sel_o)
`ifdef FWD_HAZARD_PERF_CNT_EN
        ,
        .stall_cnt_o    (stall_cnt_o),
        .fwd_cnt_o      (fwd_cnt_o)
`endif
    );

    // ---------------- scoreboard bookkeeping ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // pipe_q[0] = instruction in EX, [1] = MEM, [2] = WB.
    typedef struct {
        bit valid;
        int rd;
        bit rw;
        bit mr;
        int rs0;
        int rs1;
    } instr_t;

    instr_t pipe_q[$];
    longint exp_stall_cnt = 0;
    longint exp_fwd_cnt   = 0;
    bit     model_ready   = 0;

    function automatic bit writes(instr_t e);
        return e.valid && e.rw && (e.rd != 0);
    endfunction

    function automatic logic [1:0] sel_for(int rs);
        if (!pipe_q[0].valid) return 2'b00;
        if (writes(pipe_q[1]) && pipe_q[1].rd == rs) return 2'b10;
        if (writes(pipe_q[2]) && pipe_q[2].rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [3:0] exp_sel();
        return {sel_for(pipe_q[0].rs1), sel_for(pipe_q[0].rs0)};
    endfunction

    function automatic bit exp_stall();
        int r0;
        int r1;
        r0 = int'(id_rs_i[4:0]);
        r1 = int'(id_rs_i[9:5]);
        return id_valid_i && !flush_i && writes(pipe_q[0]) && pipe_q[0].mr &&
               (pipe_q[0].rd == r0 || pipe_q[0].rd == r1);
    endfunction

    instr_t bub;
    initial begin
        bub = '{default: 0};
        pipe_q = {bub, bub, bub};
    end

    always @(posedge clk) begin : model_update
        instr_t nx;
        bit     st;
        if (rst_i) begin
            pipe_q = {bub, bub, bub};
            exp_stall_cnt = 0;
            exp_fwd_cnt   = 0;
            model_ready   = 1;
        end else if (model_ready && !hold_i) begin
            st = exp_stall();
            if (st && exp_stall_cnt < 64'hFFFF_FFFF) exp_stall_cnt++;
            if (exp_sel() != 4'b0 && exp_fwd_cnt < 64'hFFFF_FFFF) exp_fwd_cnt++;
            if (flush_i || st) begin
                nx = bub;
            end else begin
                nx.valid = id_valid_i;
                nx.rd    = int'(id_rd_i);
                nx.rw    = id_reg_write_i;
                nx.mr    = id_mem_read_i;
                nx.rs0   = int'(id_rs_i[4:0]);
                nx.rs1   = int'(id_rs_i[9:5]);
            end
            pipe_q.push_front(nx);
            void'(pipe_q.pop_back());
        end
    end

    // Compare process: every cycle once reset has been seen.
    always @(negedge clk) begin
        if (model_ready) begin
            check("model_stall", {63'b0, stall_o}, {63'b0, exp_stall()});
            check("model_sel", {60'b0, ex_fwd_sel_o}, {60'b0, exp_sel()});
`ifdef FWD_HAZARD_PERF_CNT_EN
            check("model_stall_cnt", {32'b0, stall_cnt_o}, exp_stall_cnt);
            check("model_fwd_cnt", {32'b0, fwd_cnt_o}, exp_fwd_cnt);
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input bit v, input int rd, input bit rw, input bit mr,
                          input int rs0, input int rs1);
        id_valid_i     = v;
        id_rd_i        = REG_AW'(rd);
        id_reg_write_i = rw;
        id_mem_read_i  = mr;
        id_rs_i        = {REG_AW'(rs1), REG_AW'(rs0)};
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0);
    endtask

    task automatic expect_now(input string name, input bit st, input logic [3:0] sel);
        @(negedge clk);
        check({name, "_stall"}, {63'b0, stall_o}, {63'b0, st});
        check({name, "_sel"}, {60'b0, ex_fwd_sel_o}, {60'b0, sel});
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_i = 1'b1;
        nop();
        tick();
        tick();
        rst_i = 1'b0;
        expect_now("reset", 0, 4'b0000);
        tick();

        // add x5; sub x6 <- x5 (MEM fwd); and x11 <- x5 (WB fwd)
        set_id(1, 5, 1, 0, 1, 2);   tick();
        set_id(1, 6, 1, 0, 5, 3);   expect_now("add_in_ex", 0, 4'b0000); tick();
        set_id(1, 11, 1, 0, 5, 12); expect_now("sub_mem_fwd", 0, 4'b0010); tick();
        nop();                      expect_now("and_wb_fwd", 0, 4'b0001); tick();

        // lw x7; add x9 <- x4, x7: one stall cycle, then WB forward on rs2
        set_id(1, 7, 1, 1, 1, 0);   expect_now("lw_issue", 0, 4'b0000); tick();
        set_id(1, 9, 1, 0, 4, 7);   expect_now("load_use", 1, 4'b0000); tick();
        expect_now("stall_drop", 0, 4'b0000); tick();
        nop();                      expect_now("after_stall_fwd", 0, 4'b0100); tick();

        // x0 writer and lw x0 never forward or stall
        set_id(1, 0, 1, 0, 1, 2);   tick();
        set_id(1, 13, 1, 0, 0, 0);  tick();
        set_id(1, 0, 1, 1, 1, 2);   expect_now("x0_no_fwd", 0, 4'b0000); tick();
        set_id(1, 14, 1, 0, 0, 0);  expect_now("lw_x0_no_stall", 0, 4'b0000); tick();
        nop();                      tick();

        // MEM and WB both write x3: MEM wins on both sources
        set_id(1, 3, 1, 0, 1, 2);   tick();
        set_id(1, 3, 1, 0, 1, 2);   tick();
        set_id(1, 15, 1, 0, 3, 3);  tick();
        nop();                      expect_now("mem_beats_wb", 0, 4'b1010); tick();
        tick();

        // load-use with flush: no stall, bubble, selects 00
        set_id(1, 7, 1, 1, 1, 1);   tick();
        set_id(1, 9, 1, 0, 7, 1);
        flush_i = 1'b1;             expect_now("flush_kills_stall", 0, 4'b0000); tick();
        flush_i = 1'b0;
        nop();                      expect_now("flush_bubble", 0, 4'b0000); tick();
        tick();
        tick();

        // load-use under hold: stall held, nothing moves, one stall after release
        set_id(1, 7, 1, 1, 1, 1);   tick();
        set_id(1, 9, 1, 0, 7, 2);
        hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_now("hold_stall", 1, 4'b0000);
            tick();
        end
        hold_i = 1'b0;              expect_now("release_stall", 1, 4'b0000); tick();
        expect_now("release_bubble", 0, 4'b0000); tick();
        nop();                      expect_now("release_fwd", 0, 4'b0001); tick();

        // randomised traffic over a small register set, checked by the model
        for (int i = 0; i < 60; i++) begin
            set_id(1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
            hold_i  = ($urandom_range(0, 5) == 0);
            flush_i = ($urandom_range(0, 5) == 0);
            tick();
        end
        hold_i  = 1'b0;
        flush_i = 1'b0;

        // reset mid-run discards everything
        set_id(1, 2, 1, 0, 1, 2);   tick();
        set_id(1, 4, 1, 0, 2, 2);
        rst_i = 1'b1;               tick();
        rst_i = 1'b0;
        set_id(1, 5, 1, 0, 2, 4);   expect_now("mid_reset", 0, 4'b0000);
`ifdef FWD_HAZARD_PERF_CNT_EN
        check("mid_reset_stall_cnt", {32'b0, stall_cnt_o}, 64'd0);
        check("mid_reset_fwd_cnt", {32'b0, fwd_cnt_o}, 64'd0);
`endif
        nop();                      tick();
        tick();
        tick();
        rst_i = 1'b1;               tick();
        rst_i = 1'b0;

        // two load-use pairs and three forwarded EX cycles
        set_id(1, 7, 1, 1, 1, 0);   tick();
        set_id(1, 9, 1, 0, 7, 0);   tick();
        tick();
        set_id(1, 8, 1, 1, 1, 0);   expect_now("cnt_fwd1", 0, 4'b0001); tick();
        set_id(1, 10, 1, 0, 8, 0);  expect_now("cnt_stall2", 1, 4'b0000); tick();
        tick();
        set_id(1, 5, 1, 0, 1, 2);   expect_now("cnt_fwd2", 0, 4'b0001); tick();
        set_id(1, 6, 1, 0, 5, 2);   tick();
        nop();                      expect_now("cnt_fwd3", 0, 4'b0010); tick();
        expect_now("cnt_idle", 0, 4'b0000);
`ifdef FWD_HAZARD_PERF_CNT_EN
        check("stall_cnt_2", {32'b0, stall_cnt_o}, 64'd2);
        check("fwd_cnt_3", {32'b0, fwd_cnt_o}, 64'd3);
`endif
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the EX-stage forwarding logic.
- Keeps its own shadow pipeline of in-flight destination registers for the EX, MEM and WB stages, so MEM/WB rd and control no longer need to be routed in.
- Generates per-source forwarding selects for EX and a load-use stall request for IF/ID.
- Sits beside the ID/EX pipeline registers of the 5-stage CPU.

Parameters:
- REG_AW, 5, register-address width (x0 = address 0, never forwarded).
- NUM_SRC, 2, source operands per instruction.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active high.
- hold_i  in  1  global pipeline freeze (e.g. memory wait).
- flush_i  in  1  kill the instruction currently in ID.
- id_valid_i  in  1  ID holds a real instruction.
- id_rs_i  in  NUM_SRC*REG_AW  ID source addresses; source k at bits [k*REG_AW +: REG_AW].
- id_rd_i  in  REG_AW  ID destination address.
- id_reg_write_i  in  1  ID instruction writes the register file.
- id_mem_read_i  in  1  ID instruction is a load.
- stall_o  out  1  load-use stall; freeze PC and IF/ID, bubble into EX.
- ex_fwd_sel_o  out  2*NUM_SRC  per-source EX select; 00 = regfile, 01 = WB result, 10 = MEM ALU result; source k at [2k +: 2].
- (CNT opt) stall_cnt_o  out  CNT_W  load-use stalls inserted.
- (CNT opt) fwd_cnt_o  out  CNT_W  EX cycles with at least one non-zero select.

Behaviour:
- Stage entries:
  - EX, MEM and WB stages each hold one entry: {valid, rd, reg_write, mem_read}.
  - The EX entry also holds the NUM_SRC source addresses.
- Reset:
  - rst_i sampled high clears every valid bit and the counters.
  - This gives stall_o = 0 and ex_fwd_sel_o = 0 from the cycle after reset.
  - Reset mid-operation discards all in-flight entries. No partial state survives.
- Entry "writes":
  - An entry writes when valid && reg_write && rd != 0.
  - rd = 0 never matches, whatever reg_write is.
- stall_o (combinational, same cycle):
  - Asserted when id_valid_i && !flush_i && the EX entry is a writing load (mem_read) && rd equals any id_rs_i[k].
  - A stall lasts exactly one cycle. The next cycle the load is in MEM, so stall_o drops.
- ex_fwd_sel_o (combinational from registered state only), per source k:
  - 10 if the MEM entry writes and MEM.rd == EX.rs[k].
  - Otherwise 01 if the WB entry writes and WB.rd == EX.rs[k].
  - Otherwise 00.
  - MEM always beats WB (youngest data wins).
  - If the EX entry is invalid, all selects are 00.
- Advance priority each clock (highest first):
  - rst_i: clear everything.
  - hold_i: all entries and counters hold.
  - Otherwise:
    - WB takes MEM.
    - MEM takes EX.
    - EX takes either a bubble (valid = 0), when flush_i or stall_o is set, or the ID fields with valid = id_valid_i.
- Simultaneous events:
  - flush_i with a load-use condition: flush wins, stall_o = 0, bubble enters EX.
  - hold_i with stall_o: stall_o still reflects the hazard, but nothing advances.
- Latency:
  - An ID instruction reaches EX one un-held cycle later.
  - Its selects appear that cycle.

Optional Feature:
- Macro: FWD_HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cnt_o and fwd_cnt_o ports exist.
  - They increment by 1 on each un-held clock where the condition holds.
  - They saturate at all-ones.
  - Reset to 0.
- Undefined:
  - Ports and counters are absent. No other behaviour changes.

Decomposition:
- Shared package (fwd_pkg):
  - FWD_SEL_RF = 2'b00, FWD_SEL_WB = 2'b01, FWD_SEL_MEM = 2'b10.
  - Packed stage-entry struct typedef.
  - REG_AW default.
- One natural sub-module: fwd_src_match.
  - Combinational, one per source via generate.
  - Inputs: EX.rs[k] plus MEM/WB entries. Output: 2-bit select.
  - Reused by stall detection against the EX entry.

Test Plan:
- add x5 in ID, then dependent `sub` with rs1 = x5 next cycle -> `sub` in EX gives ex_fwd_sel_o[1:0] = 10. One cycle later with an independent instruction between -> 01.
- lw x7, then `add` with rs2 = x7 in ID -> stall_o = 1 for exactly one cycle; EX bubble. Next cycle `add` in EX -> ex_fwd_sel_o[3:2] = 01, stall_o = 0.
- Writer with rd = 0 (reg_write = 1), then dependent on x0 -> selects stay 00; lw x0 never stalls.
- MEM and WB both write x3, EX rs1 = x3 -> select 10 (MEM priority).
- Load-use condition with flush_i = 1 -> stall_o = 0; EX bubble; next-cycle selects 00. Same hazard with hold_i = 1 for 3 cycles -> stall_o stays 1, entries frozen, then one stall cycle after release.
- With FWD_HAZARD_PERF_CNT_EN: 2 load-use pairs and 3 forwarded cycles -> stall_cnt_o = 2, fwd_cnt_o = 3. rst_i mid-run -> both 0 and all selects 00 the next cycle.
